tomasulo_rs_arith: RTL

- Reservation station for the arithmetic pipe.
- Accepts dispatched ops whose source operands are either ready values or pending tags.
- Snoops the common data bus (CDB) and captures operands by tag match.
- Issues the oldest fully-ready entry to the arithmetic execution unit via the issue_t interface. It is the initiator for that unit's issue port and a consumer of its CDB output.

---
 rtl/tomasulo_pkg.sv | 74 +++++++
 rtl/tomasulo_age_matrix.sv | 44 ++++
 rtl/tomasulo_rs_arith.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared types for the arithmetic reservation station.
// Holds the word/tag/ROB/write-address types, the per-source operand record,
// the dispatch and issue payloads, the CDB broadcast record, and the helper
// that applies a CDB broadcast to a single pending source operand.
package tomasulo_pkg;

   localparam int WORD_W = 32;
   localparam int TAG_W  = 4;
   localparam int ROB_W  = 4;
   localparam int WA_W   = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [TAG_W-1:0]  tag_t;
   typedef logic [ROB_W-1:0]  robid_t;
   typedef logic [WA_W-1:0]   wa_t;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SLL = 3'd5,
      OP_SRL = 3'd6,
      OP_SLT = 3'd7
   } opcode_t;

   // One source operand: either a ready value or a tag still being waited on.
   typedef struct packed {
      logic  rdy;
      tag_t  tag;
      word_t data;
   } src_t;

   // Dispatch payload; also the storage format of a reservation-station entry.
   typedef struct packed {
      opcode_t     op;
      tag_t        tag;
      robid_t      robid;
      wa_t         wa;
      src_t [1:0]  src;
   } dispatch_t;

   typedef struct packed {
      opcode_t     op;
      tag_t        tag;
      robid_t      robid;
      wa_t         wa;
      word_t [1:0] rdata;
   } issue_t;

   typedef struct packed {
      logic   vld;
      tag_t   tag;
      word_t  wdata;
      robid_t robid;
      wa_t    wa;
   } cdb_t;

   localparam int CDB_W   = $bits(cdb_t);
   localparam int ISSUE_W = $bits(issue_t);

   // A pending source whose tag matches a valid broadcast takes the broadcast value.
   function automatic src_t src_capture(src_t s, cdb_t c);
      src_t r;
      r = s;
      if (c.vld && !s.rdy && (s.tag == c.tag)) begin
         r.rdy  = 1'b1;
         r.data = c.wdata;
      end
      return r;
   endfunction

endpackage

// File: rtl/tomasulo_age_matrix.sv
// Age matrix for oldest-first selection among N reservation-station slots.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears the matrix)
//   alloc    : one-hot slot being written this cycle (becomes youngest)
//   free     : one-hot slot being released this cycle
//   ready    : slots eligible for selection this cycle
//   oldest   : one-hot ready slot with no older ready slot (zero if none ready)
module tomasulo_age_matrix #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] alloc,
   input  logic [N-1:0] free,
   input  logic [N-1:0] ready,
   output logic [N-1:0] oldest
);

   // older_reg[i][j] = 1 means slot j is older than slot i.
   logic [N-1:0] older_reg [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         localparam logic [N-1:0] SELF = N'(1) << gi;

         // A newly allocated slot is younger than every other slot. Stale bits
         // pointing at empty slots are harmless (empty slots are never ready)
         // and are cleared when that slot is itself allocated or released.
         always_ff @(posedge clk) begin
            if (rst) begin
               older_reg[gi] <= '0;
            end else if (alloc[gi]) begin
               older_reg[gi] <= ~SELF;
            end else begin
               older_reg[gi] <= older_reg[gi] & ~alloc & ~free;
            end
         end

         assign oldest[gi] = ready[gi] & ~(|(ready & older_reg[gi]));
      end
   endgenerate

endmodule

// File: rtl/tomasulo_rs_arith.sv
// Reservation station for the arithmetic pipe.
// Holds up to N dispatched ops, wakes pending operands from the CDB, and
// issues one fully-ready op per cycle to the execution unit.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   disp_vld   : dispatch request; disp carries the op and its two sources
//   disp_rdy_r : registered, at least one free entry
//   iss_vld_r  : registered issue valid; iss_r holds the issued op and operands
//   iss_busy   : execution unit cannot accept an op this cycle
//   cdb        : common data bus broadcast snooped for operand wakeup
//   occ_r      : registered count of occupied entries
module tomasulo_rs_arith
   import tomasulo_pkg::*;
#(
   parameter int N            = 4,
   parameter int OLDEST_FIRST = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   disp_vld,
   input  dispatch_t              disp,
   output logic                   disp_rdy_r,
   output logic                   iss_vld_r,
   output issue_t                 iss_r,
   input  logic                   iss_busy,
   input  cdb_t                   cdb,
   output logic [$clog2(N+1)-1:0] occ_r
);

   localparam int OCC_W = $clog2(N+1);

   logic      vld_reg [N];
   dispatch_t ent_reg [N];

   logic [N-1:0]     ready;
   logic [N-1:0]     grant;
   logic [N-1:0]     free_slots;
   logic [N-1:0]     alloc_oh;
   logic [N-1:0]     free_oh;
   logic             do_issue;
   logic             disp_acc;
   dispatch_t        disp_cap;
   issue_t           iss_next;
   logic [OCC_W-1:0] occ_next;

   // The CDB's ROB id and write address belong to the ROB/regfile, not to us.
   logic unused_cdb;
   assign unused_cdb = ^{cdb.robid, cdb.wa};

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_vec
         assign ready[gi]      = vld_reg[gi] & ent_reg[gi].src[0].rdy & ent_reg[gi].src[1].rdy;
         assign free_slots[gi] = ~vld_reg[gi];
      end
   endgenerate

   generate
      if (OLDEST_FIRST != 0) begin : g_age
         tomasulo_age_matrix #(.N(N)) u_age (
            .clk    (clk),
            .rst    (rst),
            .alloc  (alloc_oh),
            .free   (free_oh),
            .ready  (ready),
            .oldest (grant)
         );
      end else begin : g_lowest
         // x & -x isolates the lowest set bit.
         assign grant = ready & (~ready + N'(1));
      end
   endgenerate

   assign do_issue = (|ready) & ~iss_busy;
   assign free_oh  = do_issue ? grant : '0;

   // disp_rdy_r tracks registered occupancy, so a slot freed by this cycle's
   // issue is still marked valid here and cannot be picked.
   assign disp_acc = disp_vld & disp_rdy_r;
   assign alloc_oh = disp_acc ? (free_slots & (~free_slots + N'(1))) : '0;

   // Dispatch bypass: a source whose producer broadcasts this very cycle is
   // written already captured.
   always_comb begin
      disp_cap        = disp;
      disp_cap.src[0] = src_capture(disp.src[0], cdb);
      disp_cap.src[1] = src_capture(disp.src[1], cdb);
   end

   always_comb begin
      iss_next = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            iss_next.op       = ent_reg[i].op;
            iss_next.tag      = ent_reg[i].tag;
            iss_next.robid    = ent_reg[i].robid;
            iss_next.wa       = ent_reg[i].wa;
            iss_next.rdata[0] = ent_reg[i].src[0].data;
            iss_next.rdata[1] = ent_reg[i].src[1].data;
         end
      end
   end

   always_comb begin
      occ_next = occ_r;
      if (disp_acc && !do_issue) begin
         occ_next = occ_r + OCC_W'(1);
      end else if (!disp_acc && do_issue) begin
         occ_next = occ_r - OCC_W'(1);
      end
   end

   generate
      for (gi = 0; gi < N; gi++) begin : g_ent
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_reg[gi] <= 1'b0;
            end else if (alloc_oh[gi]) begin
               vld_reg[gi] <= 1'b1;
               ent_reg[gi] <= disp_cap;
            end else begin
               if (free_oh[gi]) begin
                  vld_reg[gi] <= 1'b0;
               end
               ent_reg[gi].src[0] <= src_capture(ent_reg[gi].src[0], cdb);
               ent_reg[gi].src[1] <= src_capture(ent_reg[gi].src[1], cdb);
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_r      <= '0;
         disp_rdy_r <= 1'b1;
         iss_vld_r  <= 1'b0;
         iss_r      <= '0;
      end else begin
         occ_r      <= occ_next;
         disp_rdy_r <= (occ_next != OCC_W'(N));
         iss_vld_r  <= do_issue;
         if (do_issue) begin
            iss_r <= iss_next;
         end
      end
   end

   // Dispatch into a full station is a protocol violation; it must never allocate.
   always_ff @(posedge clk) begin
      if (!rst && disp_vld && !disp_rdy_r) begin
         assert (alloc_oh == '0);
      end
   end

endmodule
